// File: rtl/exec_store_unit.sv
// exec_store_unit: single-issue execute/store stage with ALU, load/store
// sequencing, operand forwarding from the last written-back value, status
// flags and a sticky halt.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   issueValid, opcode        instruction valid / operation select
//   destReg                   destination register address
//   srcVal1, srcVal2          register-file operands
//   used1, used2              take the last written-back value instead
//   memAddr                   load/store address
//   stall                     front end must hold its instruction (combinational)
//   destRegStore, destVal     write-back address / value
//   storeNow                  one-cycle register-file write strobe
//   memAddrLoadStore          memory address
//   memValueStore, memWrite   store data / one-cycle store strobe
//   readReq                   load request, held until data is accepted
//   memValueLoad, valueReady  load data / data valid
//   ProcessorStatusWord       C,V,Z,N in the top four bits
//   powerdown                 sticky halt indication
module exec_store_unit #(
    parameter int unsigned DW = 16,
    parameter int unsigned RW = 4,
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issueValid,
    input  logic [3:0]    opcode,
    input  logic [RW-1:0] destReg,
    input  logic [DW-1:0] srcVal1,
    input  logic [DW-1:0] srcVal2,
    input  logic          used1,
    input  logic          used2,
    input  logic [AW-1:0] memAddr,
    output logic          stall,
    output logic [RW-1:0] destRegStore,
    output logic [DW-1:0] destVal,
    output logic          storeNow,
    output logic [AW-1:0] memAddrLoadStore,
    output logic [DW-1:0] memValueStore,
    output logic          memWrite,
    output logic          readReq,
    input  logic [DW-1:0] memValueLoad,
    input  logic          valueReady,
    output logic [DW-1:0] ProcessorStatusWord,
    output logic          powerdown
);

    localparam int unsigned PW = 2 * DW;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_HLT   = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_MUL   = 4'd4;
    localparam logic [3:0] OP_SL    = 4'd5;
    localparam logic [3:0] OP_SR    = 4'd6;
    localparam logic [3:0] OP_AND   = 4'd7;
    localparam logic [3:0] OP_OR    = 4'd8;
    localparam logic [3:0] OP_NOT   = 4'd9;
    localparam logic [3:0] OP_XOR   = 4'd10;
    localparam logic [3:0] OP_LOAD  = 4'd14;
    localparam logic [3:0] OP_STORE = 4'd15;

    typedef enum logic [1:0] {IDLE, LOAD_WAIT, HALTED} state_t;

    state_t        state, stateNext;
    logic [DW-1:0] lastVal, lastValNext;
    logic [RW-1:0] loadDest, loadDestNext;
    logic          flagC, flagV, flagZ, flagN;
    logic          flagCNext, flagVNext, flagZNext, flagNNext;
    logic [RW-1:0] destRegStoreNext;
    logic [DW-1:0] destValNext;
    logic          storeNowNext;
    logic [AW-1:0] memAddrNext;
    logic [DW-1:0] memValueStoreNext;
    logic          memWriteNext;
    logic          readReqNext;
    logic          powerdownNext;

    logic [DW-1:0] val1, val2;
    logic [DW:0]   sum, diff, shl;
    logic [PW-1:0] prod;
    logic [DW-1:0] shr;
    logic [DW-1:0] aluRes;
    logic          aluC, aluV;

    assign stall = (state != IDLE);
    assign ProcessorStatusWord = {flagC, flagV, flagZ, flagN, {(DW-4){1'b0}}};

    // Forwarding from the most recent write-back
    assign val1 = used1 ? lastVal : srcVal1;
    assign val2 = used2 ? lastVal : srcVal2;

    // Extra top bit carries the ADD carry, SUB borrow and the last bit shifted out of SL
    assign sum  = {1'b0, val1} + {1'b0, val2};
    assign diff = {1'b0, val1} - {1'b0, val2};
    assign shl  = {1'b0, val1} << val2;
    assign shr  = val1 >> val2;
    assign prod = PW'(val1) * PW'(val2);

    // ALU result and C/V for the register-writing opcodes
    always_comb begin
        aluRes = '0;
        aluC   = 1'b0;
        aluV   = 1'b0;
        case (opcode)
            OP_ADD: begin
                aluRes = sum[DW-1:0];
                aluC   = sum[DW];
                aluV   = (val1[DW-1] == val2[DW-1]) && (sum[DW-1] != val1[DW-1]);
            end
            OP_SUB: begin
                aluRes = diff[DW-1:0];
                aluC   = diff[DW];
                aluV   = (val1[DW-1] != val2[DW-1]) && (diff[DW-1] != val1[DW-1]);
            end
            OP_MUL: begin
                aluRes = prod[DW-1:0];
                aluC   = |prod[PW-1:DW];
                aluV   = |prod[PW-1:DW];
            end
            OP_SL: begin
                aluRes = shl[DW-1:0];
                aluC   = shl[DW];
            end
            OP_SR:   aluRes = shr;
            OP_AND:  aluRes = val1 & val2;
            OP_OR:   aluRes = val1 | val2;
            OP_NOT:  aluRes = ~val1;
            OP_XOR:  aluRes = val1 ^ val2;
            default: aluRes = '0;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        stateNext         = state;
        lastValNext       = lastVal;
        loadDestNext      = loadDest;
        flagCNext         = flagC;
        flagVNext         = flagV;
        flagZNext         = flagZ;
        flagNNext         = flagN;
        destRegStoreNext  = destRegStore;
        destValNext       = destVal;
        storeNowNext      = 1'b0;
        memAddrNext       = memAddrLoadStore;
        memValueStoreNext = memValueStore;
        memWriteNext      = 1'b0;
        readReqNext       = readReq;
        powerdownNext     = powerdown;

        case (state)
            IDLE: begin
                if (issueValid) begin
                    case (opcode)
                        OP_NOP: ;
                        OP_ADD, OP_SUB, OP_MUL, OP_SL, OP_SR,
                        OP_AND, OP_OR, OP_NOT, OP_XOR: begin
                            destValNext      = aluRes;
                            destRegStoreNext = destReg;
                            storeNowNext     = 1'b1;
                            lastValNext      = aluRes;
                            flagCNext        = aluC;
                            flagVNext        = aluV;
                            flagZNext        = (aluRes == '0);
                            flagNNext        = aluRes[DW-1];
                        end
                        OP_LOAD: begin
                            memAddrNext  = memAddr;
                            readReqNext  = 1'b1;
                            loadDestNext = destReg;
                            stateNext    = LOAD_WAIT;
                        end
                        OP_STORE: begin
                            memAddrNext       = memAddr;
                            memValueStoreNext = val1;
                            memWriteNext      = 1'b1;
                        end
                        // HLT and the unused opcodes both halt
                        default: begin
                            powerdownNext = 1'b1;
                            stateNext     = HALTED;
                        end
                    endcase
                end
            end
            LOAD_WAIT: begin
                if (valueReady) begin
                    destValNext      = memValueLoad;
                    destRegStoreNext = loadDest;
                    storeNowNext     = 1'b1;
                    readReqNext      = 1'b0;
                    lastValNext      = memValueLoad;
                    flagCNext        = 1'b0;
                    flagVNext        = 1'b0;
                    flagZNext        = (memValueLoad == '0);
                    flagNNext        = memValueLoad[DW-1];
                    stateNext        = IDLE;
                end
            end
            HALTED: ;
            default: stateNext = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            lastVal          <= '0;
            loadDest         <= '0;
            flagC            <= 1'b0;
            flagV            <= 1'b0;
            flagZ            <= 1'b0;
            flagN            <= 1'b0;
            destRegStore     <= '0;
            destVal          <= '0;
            storeNow         <= 1'b0;
            memAddrLoadStore <= '0;
            memValueStore    <= '0;
            memWrite         <= 1'b0;
            readReq          <= 1'b0;
            powerdown        <= 1'b0;
        end else begin
            state            <= stateNext;
            lastVal          <= lastValNext;
            loadDest         <= loadDestNext;
            flagC            <= flagCNext;
            flagV            <= flagVNext;
            flagZ            <= flagZNext;
            flagN            <= flagNNext;
            destRegStore     <= destRegStoreNext;
            destVal          <= destValNext;
            storeNow         <= storeNowNext;
            memAddrLoadStore <= memAddrNext;
            memValueStore    <= memValueStoreNext;
            memWrite         <= memWriteNext;
            readReq          <= readReqNext;
            powerdown        <= powerdownNext;
        end
    end

    // Unused opcode constant kept for readability of the decode table
    logic unusedHlt;
    assign unusedHlt = (OP_HLT == 4'd1);

endmodule

// File: tb/tb_exec_store_unit.sv
// Testbench for exec_store_unit: directed sequence on a DW=16 instance with a
// write-back/store scoreboard, plus a short directed run on a DW=32 instance.
module tb_exec_store_unit;

    localparam logic [3:0] OP_NOP = 4'd0,  OP_HLT = 4'd1,  OP_ADD = 4'd2,  OP_SUB = 4'd3;
    localparam logic [3:0] OP_MUL = 4'd4,  OP_SL  = 4'd5,  OP_SR  = 4'd6,  OP_AND = 4'd7;
    localparam logic [3:0] OP_ILL = 4'd12, OP_LOAD = 4'd14, OP_STORE = 4'd15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nTests = 0;
    int nFail  = 0;

    // DW=16 instance
    logic        rst, issueValid, used1, used2, valueReady;
    logic [3:0]  opcode, destReg;
    logic [15:0] srcVal1, srcVal2, memValueLoad;
    logic [7:0]  memAddr;
    logic        stall, storeNow, memWrite, readReq, powerdown;
    logic [3:0]  destRegStore;
    logic [15:0] destVal, memValueStore, psw;
    logic [7:0]  memAddrLoadStore;

    exec_store_unit #(.DW(16), .RW(4), .AW(8)) dut16 (
        .clk(clk), .rst(rst), .issueValid(issueValid), .opcode(opcode), .destReg(destReg),
        .srcVal1(srcVal1), .srcVal2(srcVal2), .used1(used1), .used2(used2), .memAddr(memAddr),
        .stall(stall), .destRegStore(destRegStore), .destVal(destVal), .storeNow(storeNow),
        .memAddrLoadStore(memAddrLoadStore), .memValueStore(memValueStore), .memWrite(memWrite),
        .readReq(readReq), .memValueLoad(memValueLoad), .valueReady(valueReady),
        .ProcessorStatusWord(psw), .powerdown(powerdown)
    );

    // DW=32 instance
    logic        rstB, issueValidB, used1B, used2B, valueReadyB;
    logic [3:0]  opcodeB;
    logic [4:0]  destRegB, destRegStoreB;
    logic [31:0] srcVal1B, srcVal2B, memValueLoadB, destValB, memValueStoreB, pswB;
    logic [11:0] memAddrB, memAddrLoadStoreB;
    logic        stallB, storeNowB, memWriteB, readReqB, powerdownB;

    exec_store_unit #(.DW(32), .RW(5), .AW(12)) dut32 (
        .clk(clk), .rst(rstB), .issueValid(issueValidB), .opcode(opcodeB), .destReg(destRegB),
        .srcVal1(srcVal1B), .srcVal2(srcVal2B), .used1(used1B), .used2(used2B), .memAddr(memAddrB),
        .stall(stallB), .destRegStore(destRegStoreB), .destVal(destValB), .storeNow(storeNowB),
        .memAddrLoadStore(memAddrLoadStoreB), .memValueStore(memValueStoreB), .memWrite(memWriteB),
        .readReq(readReqB), .memValueLoad(memValueLoadB), .valueReady(valueReadyB),
        .ProcessorStatusWord(pswB), .powerdown(powerdownB)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nTests++;
        assert (got === exp) else begin
            nFail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference ALU for DW=16: returns {value, C, V, Z, N, 12'b0}
    function automatic logic [31:0] model16(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        longint unsigned x, y, r;
        logic [15:0] val;
        logic c, v;
        x = 64'(a); y = 64'(b); r = 0; val = 16'h0; c = 1'b0; v = 1'b0;
        case (op)
            OP_ADD: begin
                r = x + y; val = r[15:0]; c = r[16];
                v = (a[15] == b[15]) && (val[15] != a[15]);
            end
            OP_SUB: begin
                r = x - y; val = r[15:0]; c = (x < y);
                v = (a[15] != b[15]) && (val[15] != a[15]);
            end
            OP_MUL: begin
                r = x * y; val = r[15:0]; c = ((r >> 16) != 0); v = c;
            end
            OP_SL: begin
                if (y > 16)       begin val = 16'h0; c = 1'b0; end
                else if (y == 16) begin val = 16'h0; c = a[0]; end
                else if (y == 0)  begin val = a;     c = 1'b0; end
                else begin r = x << y; val = r[15:0]; c = r[16]; end
            end
            OP_SR:   val = (y >= 16) ? 16'h0 : 16'(x >> y);
            OP_AND:  val = a & b;
            4'd8:    val = a | b;
            4'd9:    val = ~a;
            4'd10:   val = a ^ b;
            default: val = 16'h0;
        endcase
        return {val, c, v, (val == 16'h0), val[15], 12'h000};
    endfunction

    typedef struct {
        bit          isMem;
        logic [7:0]  key;
        logic [15:0] val;
        logic [15:0] psw;
    } exp_t;

    exp_t        sbq[$];
    exp_t        monE;
    logic [15:0] lastModel;
    logic [15:0] pswModel;

    // Drive one instruction at a negedge; returns at the next negedge
    task automatic issue(input logic [3:0] op, input logic [3:0] dst, input logic [15:0] s1,
                         input logic [15:0] s2, input logic u1, input logic u2,
                         input logic [7:0] addr);
        logic [15:0] a, b;
        logic [31:0] m;
        exp_t e;
        a = u1 ? lastModel : s1;
        b = u2 ? lastModel : s2;
        opcode = op; destReg = dst; srcVal1 = s1; srcVal2 = s2;
        used1 = u1; used2 = u2; memAddr = addr; issueValid = 1'b1;
        if (op >= OP_ADD && op <= 4'd10) begin
            m = model16(op, a, b);
            e.isMem = 1'b0; e.key = 8'(dst); e.val = m[31:16]; e.psw = m[15:0];
            sbq.push_back(e);
            lastModel = e.val; pswModel = e.psw;
        end else if (op == OP_STORE) begin
            e.isMem = 1'b1; e.key = addr; e.val = a; e.psw = pswModel;
            sbq.push_back(e);
        end
        @(negedge clk);
        issueValid = 1'b0;
    endtask

    // Scoreboard monitor for the DW=16 instance
    always @(negedge clk) begin
        if (storeNow === 1'b1) begin
            if (sbq.size() == 0 || sbq[0].isMem) begin
                check("unexpected_storeNow", 64'(storeNow), 64'h0);
            end else begin
                monE = sbq.pop_front();
                check("wb_reg", 64'(destRegStore), 64'(monE.key[3:0]));
                check("wb_val", 64'(destVal), 64'(monE.val));
                check("wb_psw", 64'(psw), 64'(monE.psw));
            end
        end
        if (memWrite === 1'b1) begin
            if (sbq.size() == 0 || !sbq[0].isMem) begin
                check("unexpected_memWrite", 64'(memWrite), 64'h0);
            end else begin
                monE = sbq.pop_front();
                check("st_addr", 64'(memAddrLoadStore), 64'(monE.key));
                check("st_val", 64'(memValueStore), 64'(monE.val));
                check("st_noRegWrite", 64'(storeNow), 64'h0);
                check("st_psw", 64'(psw), 64'(monE.psw));
            end
        end
    end

    task automatic checkAllZero16(input string tag);
        check({tag, "_destVal"}, 64'(destVal), 64'h0);
        check({tag, "_destReg"}, 64'(destRegStore), 64'h0);
        check({tag, "_storeNow"}, 64'(storeNow), 64'h0);
        check({tag, "_memWrite"}, 64'(memWrite), 64'h0);
        check({tag, "_readReq"}, 64'(readReq), 64'h0);
        check({tag, "_psw"}, 64'(psw), 64'h0);
        check({tag, "_powerdown"}, 64'(powerdown), 64'h0);
        check({tag, "_stall"}, 64'(stall), 64'h0);
        check({tag, "_memAddr"}, 64'(memAddrLoadStore), 64'h0);
        check({tag, "_memValue"}, 64'(memValueStore), 64'h0);
    endtask

    initial begin
        logic [3:0]  rop;
        logic [15:0] rs2;
        rst = 1'b1; issueValid = 1'b0; opcode = 4'h0; destReg = 4'h0; srcVal1 = 16'h0;
        srcVal2 = 16'h0; used1 = 1'b0; used2 = 1'b0; memAddr = 8'h0; memValueLoad = 16'h0;
        valueReady = 1'b0;
        rstB = 1'b1; issueValidB = 1'b0; opcodeB = 4'h0; destRegB = 5'h0; srcVal1B = 32'h0;
        srcVal2B = 32'h0; used1B = 1'b0; used2B = 1'b0; memAddrB = 12'h0;
        memValueLoadB = 32'h0; valueReadyB = 1'b0;
        lastModel = 16'h0; pswModel = 16'h0;

        repeat (2) @(negedge clk);
        checkAllZero16("reset");
        rst = 1'b0;
        @(negedge clk);

        // Signed overflow, then single-cycle storeNow and idle flag hold
        issue(OP_ADD, 4'd3, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 8'h0);
        check("add_ovf_psw", 64'(psw), 64'h5000);
        @(negedge clk);
        check("storeNow_pulse", 64'(storeNow), 64'h0);
        check("flag_hold_idle", 64'(psw), 64'(pswModel));

        // Carry-out to zero, then forward it
        issue(OP_ADD, 4'd4, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 8'h0);
        check("add_carry_psw", 64'(psw), 64'hA000);
        issue(OP_ADD, 4'd5, 16'h1111, 16'h0005, 1'b1, 1'b0, 8'h0);
        check("fwd_add_val", 64'(destVal), 64'h0005);

        // MUL overflow and shift by exactly DW
        issue(OP_MUL, 4'd6, 16'h0100, 16'h0100, 1'b0, 1'b0, 8'h0);
        check("mul_psw", 64'(psw), 64'hE000);
        issue(OP_SL, 4'd7, 16'h0001, 16'd16, 1'b0, 1'b0, 8'h0);
        check("sl16_val", 64'(destVal), 64'h0);
        issue(OP_SR, 4'd7, 16'h8000, 16'd17, 1'b0, 1'b0, 8'h0);
        issue(OP_SUB, 4'd8, 16'h8000, 16'h0001, 1'b0, 1'b0, 8'h0);
        issue(OP_SUB, 4'd9, 16'h0001, 16'h0002, 1'b0, 1'b0, 8'h0);
        issue(OP_AND, 4'd1, 16'hF0F0, 16'h0000, 1'b0, 1'b1, 8'h0);

        // Mixed random ALU traffic with forwarding
        for (int i = 0; i < 16; i++) begin
            rop = 4'($urandom_range(2, 10));
            rs2 = (rop == OP_SL || rop == OP_SR) ? 16'($urandom_range(0, 18)) : 16'($urandom);
            issue(rop, 4'($urandom_range(0, 15)), 16'($urandom), rs2,
                  1'($urandom_range(0, 1)),
                  (rop == OP_SL || rop == OP_SR) ? 1'b0 : 1'($urandom_range(0, 1)), 8'h0);
        end

        // NOP leaves flags alone
        issue(OP_NOP, 4'd2, 16'h0, 16'h0, 1'b0, 1'b0, 8'h0);
        check("flag_hold_nop", 64'(psw), 64'(pswModel));

        // Store of a forwarded value
        issue(OP_ADD, 4'd2, 16'h1000, 16'h0234, 1'b0, 1'b0, 8'h0);
        issue(OP_STORE, 4'd0, 16'hDEAD, 16'h0, 1'b1, 1'b0, 8'h55);
        check("store_val", 64'(memValueStore), 64'h1234);
        @(negedge clk);
        check("memWrite_pulse", 64'(memWrite), 64'h0);

        // Load with data arriving three cycles late; new issues ignored meanwhile
        issue(OP_LOAD, 4'd6, 16'h0, 16'h0, 1'b0, 1'b0, 8'h3C);
        issueValid = 1'b1; opcode = OP_ADD; srcVal1 = 16'h0101; srcVal2 = 16'h0202;
        for (int k = 0; k < 3; k++) begin
            check("load_readReq", 64'(readReq), 64'h1);
            check("load_stall", 64'(stall), 64'h1);
            check("load_addr", 64'(memAddrLoadStore), 64'h3C);
            if (k < 2) @(negedge clk);
        end
        issueValid = 1'b0; memValueLoad = 16'h8001; valueReady = 1'b1;
        sbq.push_back('{isMem: 1'b0, key: 8'd6, val: 16'h8001, psw: 16'h1000});
        lastModel = 16'h8001; pswModel = 16'h1000;
        @(negedge clk);
        valueReady = 1'b0;
        check("load_done_stall", 64'(stall), 64'h0);
        check("load_done_readReq", 64'(readReq), 64'h0);
        issue(OP_ADD, 4'd7, 16'h0, 16'h0001, 1'b1, 1'b0, 8'h0);
        check("fwd_load_val", 64'(destVal), 64'h8002);

        // valueReady while idle is ignored
        valueReady = 1'b1; memValueLoad = 16'hFFFF;
        repeat (2) @(negedge clk);
        valueReady = 1'b0;
        check("vr_idle_destVal", 64'(destVal), 64'h8002);

        // Reset abandons an outstanding load; late data ignored
        issue(OP_LOAD, 4'd9, 16'h0, 16'h0, 1'b0, 1'b0, 8'h44);
        check("load2_readReq", 64'(readReq), 64'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; valueReady = 1'b1; memValueLoad = 16'h0BAD;
        lastModel = 16'h0; pswModel = 16'h0;
        check("rst_load_readReq", 64'(readReq), 64'h0);
        check("rst_load_stall", 64'(stall), 64'h0);
        repeat (2) @(negedge clk);
        valueReady = 1'b0;
        check("late_data_destVal", 64'(destVal), 64'h0);
        issue(OP_ADD, 4'd3, 16'h9999, 16'h0007, 1'b1, 1'b0, 8'h0);
        check("last_cleared", 64'(destVal), 64'h0007);

        // Illegal opcode halts and ignores everything until reset
        issue(OP_ILL, 4'd1, 16'h0, 16'h0, 1'b0, 1'b0, 8'h0);
        for (int k = 0; k < 10; k++) begin
            check("halt_powerdown", 64'(powerdown), 64'h1);
            check("halt_stall", 64'(stall), 64'h1);
            issueValid = 1'b1; opcode = 4'($urandom_range(2, 15));
            srcVal1 = 16'($urandom); valueReady = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        check("halt_readReq", 64'(readReq), 64'h0);
        opcode = OP_ADD; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; issueValid = 1'b0; valueReady = 1'b0;
        lastModel = 16'h0; pswModel = 16'h0;
        checkAllZero16("halt_rst");
        issue(OP_ADD, 4'd1, 16'h0002, 16'h0003, 1'b0, 1'b0, 8'h0);

        // HLT opcode
        issue(OP_HLT, 4'd0, 16'h0, 16'h0, 1'b0, 1'b0, 8'h0);
        check("hlt_powerdown", 64'(powerdown), 64'h1);
        check("hlt_stall", 64'(stall), 64'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("hlt_rst_powerdown", 64'(powerdown), 64'h0);

        // DW=32 instance
        check("b_reset_destVal", 64'(destValB), 64'h0);
        check("b_reset_psw", 64'(pswB), 64'h0);
        check("b_reset_stall", 64'(stallB), 64'h0);
        rstB = 1'b0;
        issueValidB = 1'b1; opcodeB = OP_ADD; destRegB = 5'd17;
        srcVal1B = 32'h7FFF_FFFF; srcVal2B = 32'h0000_0001;
        @(negedge clk);
        issueValidB = 1'b0;
        check("b_add_storeNow", 64'(storeNowB), 64'h1);
        check("b_add_reg", 64'(destRegStoreB), 64'd17);
        check("b_add_val", 64'(destValB), 64'h8000_0000);
        check("b_add_psw", 64'(pswB), 64'h5000_0000);
        issueValidB = 1'b1; opcodeB = OP_MUL; srcVal1B = 32'h0001_0000; srcVal2B = 32'h0001_0000;
        @(negedge clk);
        issueValidB = 1'b0;
        check("b_mul_val", 64'(destValB), 64'h0);
        check("b_mul_psw", 64'(pswB), 64'hE000_0000);
        issueValidB = 1'b1; opcodeB = OP_STORE; memAddrB = 12'hABC; srcVal1B = 32'hCAFE_F00D;
        @(negedge clk);
        issueValidB = 1'b0;
        check("b_st_memWrite", 64'(memWriteB), 64'h1);
        check("b_st_addr", 64'(memAddrLoadStoreB), 64'hABC);
        check("b_st_val", 64'(memValueStoreB), 64'hCAFE_F00D);
        check("b_st_storeNow", 64'(storeNowB), 64'h0);
        issueValidB = 1'b1; opcodeB = OP_ILL;
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            opcodeB = OP_ADD; srcVal1B = $urandom;
            @(negedge clk);
            check("b_halt_powerdown", 64'(powerdownB), 64'h1);
            check("b_halt_stall", 64'(stallB), 64'h1);
            check("b_halt_storeNow", 64'(storeNowB), 64'h0);
        end
        rstB = 1'b1;
        @(negedge clk);
        rstB = 1'b0; issueValidB = 1'b0;
        check("b_rst_powerdown", 64'(powerdownB), 64'h0);
        check("b_rst_stall", 64'(stallB), 64'h0);
        check("b_rst_destVal", 64'(destValB), 64'h0);
        check("b_rst_psw", 64'(pswB), 64'h0);
        check("b_rst_memAddr", 64'(memAddrLoadStoreB), 64'h0);

        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sbq.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/exec_store_unit.md
EXEC_STORE_UNIT -- requirements
Module: exec_store_unit

Interface
REQ-001 Parameter DW, 16, data/register value width (>=8).
REQ-002 Parameter RW, 4, register-file address width.
REQ-003 Parameter AW, 8, memory address width.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 issueValid  input  1  opcode/operands valid this cycle.
REQ-007 opcode  input  4  operation select.
REQ-008 destReg  input  RW  destination register address.
REQ-009 srcVal1, srcVal2  input  DW each  register-file operand values.
REQ-010 used1, used2  input  1 each  use the last written-back value instead of srcVal1/srcVal2.
REQ-011 memAddr  input  AW  load/store address.
REQ-012 stall  output  1  front end holds its current instruction while high.
REQ-013 destRegStore  output  RW  write-back register address.
REQ-014 destVal  output  DW  write-back value.
REQ-015 storeNow  output  1  one-cycle register-file write strobe.
REQ-016 memAddrLoadStore  output  AW  memory address.
REQ-017 memValueStore  output  DW  store data.
REQ-018 memWrite  output  1  one-cycle store strobe.
REQ-019 readReq  output  1  load request; held high until data is accepted.
REQ-020 memValueLoad  input  DW  load data.
REQ-021 valueReady  input  1  load data valid; level sampled on clk.
REQ-022 ProcessorStatusWord  output  DW  flags: C=[DW-1], V=[DW-2], Z=[DW-3], N=[DW-4]; other bits 0.
REQ-023 powerdown  output  1  sticky halt indication.

Function
REQ-024 States: IDLE, LOAD_WAIT, HALTED; an instruction is accepted only in IDLE with issueValid=1.
REQ-025 stall is combinational: 1 when state is LOAD_WAIT or HALTED, else 0.
REQ-026 Operand select: val1 = used1 ? LAST : srcVal1; val2 = used2 ? LAST : srcVal2. LAST is an internal DW register loaded with destVal on every storeNow.
REQ-027 Opcodes: 0 NOP; 1 HLT; 2 ADD; 3 SUB; 4 MUL; 5 SL; 6 SR; 7 AND; 8 OR; 9 NOT(val1); 10 XOR; 14 LOAD; 15 STORE; 11-13 illegal.
REQ-028 ALU ops (2-10): destVal, destRegStore=destReg and storeNow=1 are registered on the accepting edge, giving 1-cycle latency; all four flags are updated on the same edge.
REQ-029 ADD/SUB: C = bit DW of the (DW+1)-bit result; SUB C is the borrow. V = signed overflow: ADD when operand signs are equal and result sign differs; SUB when operand signs differ and result sign differs from val1.
REQ-030 MUL: destVal = low DW bits of the 2*DW unsigned product; C = V = 1 when the high DW bits are nonzero.
REQ-031 SL/SR: shift amount is the unsigned value of val2; amount >= DW gives destVal=0. SL C = last bit shifted out (0 if amount is 0 or >= DW+1). SR C=0. V=0 for all shifts.
REQ-032 AND/OR/NOT/XOR: C=0, V=0.
REQ-033 Z = (destVal==0) and N = destVal[DW-1] for every ALU op and every load completion.
REQ-034 Flags hold their value on NOP, STORE, HLT and idle cycles.
REQ-035 LOAD: on accept, register memAddrLoadStore=memAddr, readReq=1, and latch destReg; go to LOAD_WAIT.
REQ-036 LOAD_WAIT, valueReady=1 at an edge: destVal=memValueLoad, destRegStore=latched destReg, storeNow=1, readReq=0, Z/N updated, C=V=0, LAST updated; go to IDLE.
REQ-037 LOAD_WAIT, valueReady=0: hold all outputs, stay in LOAD_WAIT; no timeout.
REQ-038 valueReady while in IDLE or HALTED is ignored.
REQ-039 STORE: on accept, register memAddrLoadStore=memAddr and memValueStore=val1 (forwarding applies), and pulse memWrite=1 for one cycle; no register write occurs.
REQ-040 HLT or illegal opcode: powerdown=1 and go to HALTED; HALTED ignores all inputs until rst.
REQ-041 storeNow and memWrite are 0 in every cycle not named above.

Reset
REQ-042 rst=1 at an edge overrides all other events, including valueReady and issueValid in the same cycle.
REQ-043 Reset values: state IDLE; all outputs, LAST and flags 0 (powerdown=0, readReq=0, stall=0).
REQ-044 rst during LOAD_WAIT abandons the load; readReq is 0 from the following cycle and late data is ignored.

Verification
REQ-045 DW=16: ADD 0x7FFF+0x0001 -> destVal=0x8000, V=1, N=1, C=0, Z=0, storeNow for one cycle.
REQ-046 ADD 0xFFFF+0x0001 -> destVal=0x0000, C=1, Z=1, V=0; next instruction ADD with used1=1 and srcVal2=5 -> destVal=0x0005.
REQ-047 MUL 0x0100*0x0100 -> destVal=0x0000, C=V=1, Z=1; SL 0x0001 by 16 -> destVal=0, Z=1.
REQ-048 LOAD addr 0x3C with valueReady delayed 3 cycles -> readReq and stall high for 3 cycles; then destVal=memValueLoad, storeNow pulse, stall=0.
REQ-049 STORE with used1=1 after an ADD that produced 0x1234 -> memWrite pulse, memValueStore=0x1234, storeNow=0.
REQ-050 Opcode 12 -> powerdown=1 and stall=1 held across 10 cycles of further input; rst -> all outputs 0 and state IDLE. Repeat at DW=32, RW=5, AW=12.
